// File: rtl/adc_frame_uplink.sv
// Captures one frame of DEPTH ADC samples, then sends each sample as two bytes
// over the Avalon JTAG UART, waiting for a per-sample acknowledge byte.
module adc_frame_uplink #(
  parameter int unsigned DEPTH    = 128,
  parameter int unsigned SAMPLE_W = 10
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                abort,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  output logic                busy,
  output logic                done,
  output logic [7:0]          sample_idx,
  output logic                av_read,
  output logic                av_write,
  output logic [31:0]         av_writedata,
  input  logic [31:0]         av_readdata,
  input  logic                av_waitrequest
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CAPTURE  = 3'd1,
    SEND_LO  = 3'd2,
    SEND_HI  = 3'd3,
    WAIT_ACK = 3'd4,
    ACK_GAP  = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [7:0]          idx_q, idx_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                mem_we;
  logic [SAMPLE_W-1:0] mem_q [DEPTH];

  logic       last;
  logic [7:0] idx_inc;
  logic       ack;
  logic       unused_rdata;

  assign last    = (idx_q == 8'(DEPTH - 1));
  assign idx_inc = idx_q + 8'd1;
  assign ack     = av_readdata[15] && (av_readdata[7:6] == 2'b10);
  assign unused_rdata = ^{av_readdata[31:16], av_readdata[14:8], av_readdata[5:0]};

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    idx_d   = idx_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CAPTURE;
          busy_d  = 1'b1;
          idx_d   = '0;
        end
      end
      CAPTURE: begin
        if (sample_valid) begin
          mem_we = 1'b1;
          if (last) begin
            // buf[0] was written long ago, so the first low byte can be loaded
            // in the same cycle as the final capture.
            state_d = SEND_LO;
            idx_d   = '0;
            wr_d    = 1'b1;
            wdata_d = {24'b0, 3'b000, mem_q[0][4:0]};
          end else begin
            idx_d = idx_inc;
          end
        end
      end
      SEND_LO: begin
        if (!av_waitrequest) begin
          state_d = SEND_HI;
          wdata_d = {24'b0, 3'b111, mem_q[idx_q[AW-1:0]][9:5]};
        end
      end
      SEND_HI: begin
        if (!av_waitrequest) begin
          state_d = WAIT_ACK;
          wr_d    = 1'b0;
          rd_d    = 1'b1;
        end
      end
      WAIT_ACK: begin
        if (!av_waitrequest) begin
          rd_d = 1'b0;
          if (!ack) begin
            state_d = ACK_GAP;
          end else if (last) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            idx_d   = '0;
          end else begin
            state_d = SEND_LO;
            idx_d   = idx_inc;
            wr_d    = 1'b1;
            wdata_d = {24'b0, 3'b000, mem_q[idx_inc[AW-1:0]][4:0]};
          end
        end
      end
      ACK_GAP: begin
        state_d = WAIT_ACK;
        rd_d    = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      idx_d   = '0;
      rd_d    = 1'b0;
      wr_d    = 1'b0;
      wdata_d = '0;
      mem_we  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      idx_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      idx_q   <= idx_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx_q[AW-1:0]] <= sample_in;
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign sample_idx   = idx_q;
  assign av_read      = rd_q;
  assign av_write     = wr_q;
  assign av_writedata = wdata_q;

endmodule
